instruction_fetch_unit: RTL and testbench

INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

---
 rtl/mips_pkg.sv | 22 ++
 rtl/instr_rom.sv | 23 ++
 rtl/instruction_fetch_unit.sv | 121 ++++++++++++
 tb/tb_instruction_fetch_unit.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS opcodes, fetch state encoding and FIFO entry type
package mips_pkg;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  localparam logic [31:0] NOP = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_FLUSH = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fifo_entry_t;

endpackage

// File: rtl/instr_rom.sv
// rtl/instr_rom.sv - instruction memory: one synchronous read port, one word write port
module instr_rom #(
  parameter int WORDS = 64,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata
);

  logic [31:0] mem [WORDS];

  // Both updates are non-blocking, so a same-cycle write to the read address returns the old word.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - sequential fetch into a 2-entry output FIFO
// Branch redirect/flush is enabled by defining IFU_BRANCH_REDIRECT_EN.
module instruction_fetch_unit
  import mips_pkg::*;
#(
  parameter int          IMEM_WORDS = 64,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          fetch_en,
  input  logic                          imem_we,
  input  logic [$clog2(IMEM_WORDS)-1:0] imem_waddr,
  input  logic [31:0]                   imem_wdata,
  output logic [31:0]                   instr_out,
  output logic [31:0]                   pc_out,
  output logic                          instr_valid,
  input  logic                          instr_ready,
  input  logic                          redirect_valid,
  input  logic [31:0]                   redirect_pc
);

  localparam int AW = $clog2(IMEM_WORDS);

  fetch_state_t state;
  logic [31:0]  pc;
  logic [31:0]  inflight_pc;
  logic         inflight;
  logic [1:0]   count;
  logic         rd_ptr;
  logic         wr_ptr;
  fifo_entry_t  fifo_q [2];
  fifo_entry_t  head;
  logic [31:0]  rom_rdata;

  logic         redir;
  logic [31:0]  redir_pc;
  logic         pop;
  logic         push;
  logic         issue;
  logic [1:0]   occupancy;

`ifdef IFU_BRANCH_REDIRECT_EN
  logic unused_redirect;
  assign redir           = redirect_valid;
  assign redir_pc        = {redirect_pc[31:2], 2'b00};
  assign unused_redirect = ^redirect_pc[1:0];
`else
  logic unused_redirect;
  assign redir           = 1'b0;
  assign redir_pc        = RESET_PC;
  assign unused_redirect = ^{redirect_valid, redirect_pc};
`endif

  assign head        = fifo_q[rd_ptr];
  assign instr_valid = (count != 2'd0);
  assign instr_out   = instr_valid ? head.instr : NOP;
  assign pc_out      = instr_valid ? head.pc : 32'h0000_0000;

  assign pop  = instr_valid && instr_ready;
  assign push = inflight && !redir;

  // Space check counts the outstanding read and credits a same-cycle pop.
  assign occupancy = count + {1'b0, inflight} - {1'b0, pop};
  assign issue     = fetch_en && !redir && (occupancy <= 2'd1);

  instr_rom #(
    .WORDS (IMEM_WORDS),
    .AW    (AW)
  ) u_rom (
    .clk   (clk),
    .re    (issue),
    .raddr (pc[AW+1:2]),
    .rdata (rom_rdata),
    .we    (imem_we),
    .waddr (imem_waddr),
    .wdata (imem_wdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      pc          <= RESET_PC;
      inflight_pc <= 32'h0000_0000;
      inflight    <= 1'b0;
      count       <= 2'd0;
      rd_ptr      <= 1'b0;
      wr_ptr      <= 1'b0;
      fifo_q[0]   <= '0;
      fifo_q[1]   <= '0;
    end else if (redir) begin
      // Redirect wins over any push/pop this cycle; the pending read result is discarded.
      state    <= S_FLUSH;
      pc       <= redir_pc;
      inflight <= 1'b0;
      count    <= 2'd0;
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        pc          <= pc + 32'd4;
        inflight_pc <= pc;
      end
      if (push) begin
        fifo_q[wr_ptr] <= '{instr: rom_rdata, pc: inflight_pc};
        wr_ptr         <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};

      case (state)
        S_IDLE:  if (fetch_en) state <= S_FETCH;
        S_FETCH: if (!fetch_en) state <= S_IDLE;
        S_FLUSH: state <= fetch_en ? S_FETCH : S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - directed self-checking bench for instruction_fetch_unit
module tb_instruction_fetch_unit;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_en = 1'b0;
  logic        fetch_en4 = 1'b0;
  logic        imem_we = 1'b0;
  logic        imem_we4 = 1'b0;
  logic [5:0]  imem_waddr = '0;
  logic [1:0]  imem_waddr4 = '0;
  logic [31:0] imem_wdata = '0;
  logic        instr_ready = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] instr_out, pc_out, instr_out4, pc_out4;
  logic        instr_valid, instr_valid4;

  int pass_cnt = 0;
  int total = 0;

  always #5 clk = ~clk;

  instruction_fetch_unit #(.IMEM_WORDS(64), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en),
    .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .instr_out(instr_out), .pc_out(pc_out), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  instruction_fetch_unit #(.IMEM_WORDS(4), .RESET_PC(32'h0)) dut4 (
    .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en4),
    .imem_we(imem_we4), .imem_waddr(imem_waddr4), .imem_wdata(imem_wdata),
    .instr_out(instr_out4), .pc_out(pc_out4), .instr_valid(instr_valid4),
    .instr_ready(instr_ready), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  function automatic logic [31:0] mem_word(input int idx);
    case (idx)
      0:       mem_word = {OP_LW, 5'd0, 5'd8, 16'h0000};
      1:       mem_word = {OP_SW, 5'd0, 5'd8, 16'h0004};
      2:       mem_word = {OP_RTYPE, 5'd8, 5'd9, 5'd10, 5'd0, 6'b100000};
      3:       mem_word = {OP_BEQ, 5'd8, 5'd9, 16'hFFFC};
      default: mem_word = {6'b001000, 5'd0, 5'd9, idx[15:0]};
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    fetch_en = 1'b0;
    fetch_en4 = 1'b0;
    instr_ready = 1'b0;
    redirect_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic load_mem();
    for (int i = 0; i < 64; i++) begin
      imem_we = 1'b1;
      imem_waddr = 6'(i);
      imem_wdata = mem_word(i);
      tick();
    end
    imem_we = 1'b0;
    for (int i = 0; i < 4; i++) begin
      imem_we4 = 1'b1;
      imem_waddr4 = 2'(i);
      imem_wdata = 32'h4000_0000 + 32'(i);
      tick();
    end
    imem_we4 = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    total++; if (instr_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", instr_valid); else pass_cnt++;
    total++; if (instr_out !== 32'h0) $display("FAIL reset_instr got %h want 00000000", instr_out); else pass_cnt++;
    total++; if (pc_out !== 32'h0) $display("FAIL reset_pc_out got %h want 00000000", pc_out); else pass_cnt++;
    total++; if (dut.pc !== 32'h0) $display("FAIL reset_pc got %h want 00000000", dut.pc); else pass_cnt++;
    total++; if (dut.count !== 2'd0) $display("FAIL reset_count got %0d want 0", dut.count); else pass_cnt++;
    total++; if (dut.state !== S_IDLE) $display("FAIL reset_state got %0d want %0d", dut.state, S_IDLE); else pass_cnt++;
  endtask

  task automatic test_stream();
    do_reset();
    fetch_en = 1'b1;
    instr_ready = 1'b1;
    total++; if (instr_valid !== 1'b0) $display("FAIL stream_c0_valid got %b want 0", instr_valid); else pass_cnt++;
    tick();
    total++; if (instr_valid !== 1'b0) $display("FAIL stream_c1_valid got %b want 0", instr_valid); else pass_cnt++;
    tick();
    for (int k = 0; k < 4; k++) begin
      total++; if (instr_valid !== 1'b1) $display("FAIL stream_valid_%0d got %b want 1", k, instr_valid); else pass_cnt++;
      total++; if (pc_out !== 32'(4 * k)) $display("FAIL stream_pc_%0d got %h want %h", k, pc_out, 32'(4 * k)); else pass_cnt++;
      total++; if (instr_out !== mem_word(k)) $display("FAIL stream_instr_%0d got %h want %h", k, instr_out, mem_word(k)); else pass_cnt++;
      tick();
    end
  endtask

  task automatic test_backpressure();
    int got;
    do_reset();
    fetch_en = 1'b1;
    instr_ready = 1'b0;
    repeat (5) tick();
    total++; if (dut.count !== 2'd2) $display("FAIL bp_count got %0d want 2", dut.count); else pass_cnt++;
    total++; if (dut.pc !== 32'd8) $display("FAIL bp_pc got %h want 00000008", dut.pc); else pass_cnt++;
    total++; if (pc_out !== 32'd0) $display("FAIL bp_head_pc got %h want 00000000", pc_out); else pass_cnt++;
    instr_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 20 && got < 6; c++) begin
      if (instr_valid) begin
        total++; if (pc_out !== 32'(4 * got)) $display("FAIL bp_seq_pc_%0d got %h want %h", got, pc_out, 32'(4 * got)); else pass_cnt++;
        total++; if (instr_out !== mem_word(got)) $display("FAIL bp_seq_instr_%0d got %h want %h", got, instr_out, mem_word(got)); else pass_cnt++;
        got++;
      end
      tick();
    end
    total++; if (got != 6) $display("FAIL bp_delivered got %0d want 6", got); else pass_cnt++;
  endtask

`ifdef IFU_BRANCH_REDIRECT_EN
  task automatic test_redirect();
    bit seen;
    do_reset();
    fetch_en = 1'b1;
    instr_ready = 1'b0;
    repeat (5) tick();
    instr_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0041;
    tick();
    redirect_valid = 1'b0;
    total++; if (instr_valid !== 1'b0) $display("FAIL redir_drop got %b want 0", instr_valid); else pass_cnt++;
    total++; if (dut.state !== S_FLUSH) $display("FAIL redir_state got %0d want %0d", dut.state, S_FLUSH); else pass_cnt++;
    seen = 0;
    for (int c = 0; c < 8 && !seen; c++) begin
      if (instr_valid) begin
        seen = 1;
        total++; if (pc_out !== 32'h40) $display("FAIL redir_pc got %h want 00000040", pc_out); else pass_cnt++;
        total++; if (instr_out !== mem_word(16)) $display("FAIL redir_instr got %h want %h", instr_out, mem_word(16)); else pass_cnt++;
      end
      tick();
    end
    total++; if (!seen) $display("FAIL redir_timeout got none want pc 00000040"); else pass_cnt++;
    total++; if (pc_out !== 32'h44) $display("FAIL redir_next_pc got %h want 00000044", pc_out); else pass_cnt++;
  endtask
`else
  task automatic test_redirect_ignored();
    int got;
    do_reset();
    fetch_en = 1'b1;
    instr_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 14; c++) begin
      redirect_valid = (c == 3 || c == 4);
      redirect_pc = 32'h0000_0040;
      if (instr_valid) begin
        total++; if (pc_out !== 32'(4 * got)) $display("FAIL noredir_pc_%0d got %h want %h", got, pc_out, 32'(4 * got)); else pass_cnt++;
        total++; if (instr_out !== mem_word(got)) $display("FAIL noredir_instr_%0d got %h want %h", got, instr_out, mem_word(got)); else pass_cnt++;
        got++;
      end
      tick();
    end
    redirect_valid = 1'b0;
    total++; if (got != 12) $display("FAIL noredir_count got %0d want 12", got); else pass_cnt++;
  endtask
`endif

  task automatic test_reset_mid();
    bit seen;
    do_reset();
    fetch_en = 1'b1;
    instr_ready = 1'b1;
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    total++; if (instr_valid !== 1'b0) $display("FAIL rstmid_valid got %b want 0", instr_valid); else pass_cnt++;
    total++; if (instr_out !== NOP) $display("FAIL rstmid_instr got %h want 00000000", instr_out); else pass_cnt++;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 8 && !seen; c++) begin
      if (instr_valid) begin
        seen = 1;
        total++; if (pc_out !== 32'h0) $display("FAIL rstmid_pc got %h want 00000000", pc_out); else pass_cnt++;
        total++; if (instr_out !== mem_word(0)) $display("FAIL rstmid_first got %h want %h", instr_out, mem_word(0)); else pass_cnt++;
      end
      tick();
    end
    total++; if (!seen) $display("FAIL rstmid_timeout got none want pc 00000000"); else pass_cnt++;
  endtask

  task automatic test_wrap();
    int got;
    do_reset();
    fetch_en4 = 1'b1;
    instr_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 16 && got < 6; c++) begin
      if (instr_valid4) begin
        total++; if (pc_out4 !== 32'(4 * got)) $display("FAIL wrap_pc_%0d got %h want %h", got, pc_out4, 32'(4 * got)); else pass_cnt++;
        total++; if (instr_out4 !== 32'h4000_0000 + 32'(got % 4)) $display("FAIL wrap_instr_%0d got %h want %h", got, instr_out4, 32'h4000_0000 + 32'(got % 4)); else pass_cnt++;
        got++;
      end
      tick();
    end
    total++; if (got != 6) $display("FAIL wrap_delivered got %0d want 6", got); else pass_cnt++;
    fetch_en4 = 1'b0;
  endtask

  initial begin
    test_reset();
    load_mem();
    test_stream();
    test_backpressure();
`ifdef IFU_BRANCH_REDIRECT_EN
    test_redirect();
`else
    test_redirect_ignored();
`endif
    test_reset_mid();
    test_wrap();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
